compare_sweeper: RTL and testbench

Self-checking operand sequencer that sits directly upstream of the 2-bit magnitude comparator and also consumes its outputs. On a start request it drives all 2^(2*WIDTH) operand pairs onto the comparator inputs in ascending order. After a settle interval it samples the comparator's o1/o2/o3 results and checks them against an internal golden model. It reports error statistics to board LEDs/7-seg logic.

---
 rtl/compare_sweeper_pkg.sv | 33 +++
 rtl/compare_sweeper_cmp_golden.sv | 19 +
 rtl/compare_sweeper.sv | 135 +++++++++++++
 tb/tb_compare_sweeper.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/compare_sweeper_pkg.sv
// Shared types and constants for the comparator sweeper.
// States, default sizing, and {gt,eq,lt} result bit positions.
package compare_sweeper_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int DEF_WIDTH = 2;
  localparam int DEF_DWELL = 4;

  localparam int GT = 2;
  localparam int EQ = 1;
  localparam int LT = 0;

  // Pack three comparator flags into {gt,eq,lt} order.
  function automatic logic [2:0] pack_res(
    input logic gt,
    input logic eq,
    input logic lt
  );
    logic [2:0] r;
    r     = '0;
    r[GT] = gt;
    r[EQ] = eq;
    r[LT] = lt;
    return r;
  endfunction

endpackage

// File: rtl/compare_sweeper_cmp_golden.sv
// Combinational reference magnitude comparator.
// Ports: a_i, b_i operands; res_o = {gt,eq,lt}.
module cmp_golden
  import compare_sweeper_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [2:0]       res_o
);

  always_comb begin
    res_o = pack_res(a_i > b_i,
                     a_i == b_i,
                     a_i < b_i);
  end

endmodule

// File: rtl/compare_sweeper.sv
// Operand sweeper + checker for a magnitude comparator.
// Ports: clk/rst_n, start/pause in; in1/in2 out; o1..o3 in; status out.
module compare_sweeper
  import compare_sweeper_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DWELL = DEF_DWELL
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               pause,
  output logic [WIDTH-1:0]   in1,
  output logic [WIDTH-1:0]   in2,
  input  logic               o1,
  input  logic               o2,
  input  logic               o3,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic               err_valid,
  output logic [2*WIDTH-1:0] first_err_idx
);

  localparam int IW = 2 * WIDTH;
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

  state_e        state_q;
  logic [IW-1:0] idx_q;
  logic [IW-1:0] idx_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          busy_q;
  logic          done_q;
  logic [IW:0]   err_count_q;
  logic [IW:0]   err_count_d;
  logic          err_valid_q;
  logic [IW-1:0] first_err_q;

  logic [2:0]    exp_res;
  logic [2:0]    obs_res;
  logic          mismatch;
  logic          idx_last;
  logic          cnt_last;

  cmp_golden #(
    .WIDTH (WIDTH)
  ) u_golden (
    .a_i   (idx_q[IW-1:WIDTH]),
    .b_i   (idx_q[WIDTH-1:0]),
    .res_o (exp_res)
  );

  // Any deviation counts, including zero-hot and multi-hot.
  assign obs_res     = pack_res(o1, o2, o3);
  assign mismatch    = (obs_res != exp_res);
  assign idx_last    = &idx_q;
  assign cnt_last    = (cnt_q == CNT_LAST);
  assign idx_d       = idx_q + IW'(1);
  assign cnt_d       = cnt_q + CW'(1);
  assign err_count_d = err_count_q + (IW + 1)'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_count_q <= '0;
      err_valid_q <= 1'b0;
      first_err_q <= '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          // Fresh sweep: results cleared on the same edge.
          if (start) begin
            state_q     <= DRIVE;
            idx_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            err_count_q <= '0;
            err_valid_q <= 1'b0;
            first_err_q <= '0;
          end
        end
        DRIVE: begin
          if (!pause) begin
            if (cnt_last) begin
              state_q <= CHECK;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_d;
            end
          end
        end
        CHECK: begin
          if (mismatch) begin
            err_count_q <= err_count_d;
            if (!err_valid_q) begin
              err_valid_q <= 1'b1;
              first_err_q <= idx_q;
            end
          end
          if (idx_last) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= DRIVE;
            idx_q   <= idx_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign in1           = idx_q[IW-1:WIDTH];
  assign in2           = idx_q[WIDTH-1:0];
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = done_q && (err_count_q == '0);
  assign err_count     = err_count_q;
  assign err_valid     = err_valid_q;
  assign first_err_idx = first_err_q;

endmodule

// File: tb/tb_compare_sweeper.sv
// Bench for compare_sweeper with a fault-injectable comparator.
// Scoreboard of expected vectors/arrival cycles per sweep.
module tb_compare_sweeper;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       pause;
  logic [1:0] in1;
  logic [1:0] in2;
  logic       o1;
  logic       o2;
  logic       o3;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] err_count;
  logic       err_valid;
  logic [3:0] first_err_idx;

  int fault = 0;
  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    logic [3:0] vec;
    int         cyc;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  compare_sweeper dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .pause         (pause),
    .in1           (in1),
    .in2           (in2),
    .o1            (o1),
    .o2            (o2),
    .o3            (o3),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count),
    .err_valid     (err_valid),
    .first_err_idx (first_err_idx)
  );

  // Comparator under test: f=0 good, 1 eq stuck 0,
  // 2 gt/lt swapped, 3 all outputs 0.
  function automatic logic [2:0] resp(
    input logic [1:0] a,
    input logic [1:0] b,
    input int         f
  );
    logic g, e, l;
    g = a > b;
    e = a == b;
    l = a < b;
    case (f)
      1:       return {g, 1'b0, l};
      2:       return {l, e, g};
      3:       return 3'b000;
      default: return {g, e, l};
    endcase
  endfunction

  always_comb begin
    {o1, o2, o3} = resp(in1, in2, fault);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_sweep(
    input int    f,
    input int    p_at,
    input int    p_len,
    input bit    hold,
    input string tag
  );
    int         errs;
    int         first;
    bit         seen;
    int         pv;
    int         c;
    int         busy_n;
    int         done_c;
    bit         got_done;
    logic [3:0] prev;
    logic [3:0] vv;
    exp_t       e;
    fault = f;
    errs  = 0;
    first = 0;
    seen  = 0;
    pv    = (p_len > 0) ? p_at / 5 : 99;
    sbq.delete();
    for (int v = 0; v < 16; v++) begin
      vv = v[3:0];
      if (resp(vv[3:2], vv[1:0], f) != resp(vv[3:2], vv[1:0], 0)) begin
        if (!seen) first = v;
        seen = 1;
        errs++;
      end
      e.vec = vv;
      e.cyc = v * 5 + ((v > pv) ? p_len : 0);
      sbq.push_back(e);
    end
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    c        = 0;
    busy_n   = 0;
    done_c   = -1;
    got_done = 0;
    prev     = 4'hx;
    while (c < 300 && !got_done) begin
      if (busy) begin
        busy_n++;
        if (c == 0 || {in1, in2} !== prev) begin
          n_checks++;
          if (sbq.size() == 0) begin
            $display("FAIL %s extra_vec got %h at cyc %0d want none",
                     tag, {in1, in2}, c);
          end else begin
            e = sbq.pop_front();
            if ({in1, in2} !== e.vec || c != e.cyc)
              $display("FAIL %s vec got %h@%0d want %h@%0d",
                       tag, {in1, in2}, c, e.vec, e.cyc);
            else
              n_pass++;
          end
        end
        prev = {in1, in2};
      end
      if (done) begin
        got_done = 1;
        done_c   = c;
        start    = 1'b0;
        pause    = 1'b0;
      end else begin
        pause = (p_len > 0 && c >= p_at && c < p_at + p_len);
        tick();
        c++;
      end
    end
    pause = 1'b0;
    n_checks++;
    if (done_c != 80 + p_len)
      $display("FAIL %s done_cyc got %0d want %0d", tag, done_c, 80 + p_len);
    else
      n_pass++;
    n_checks++;
    if (busy_n != 80 + p_len)
      $display("FAIL %s busy_cycles got %0d want %0d",
               tag, busy_n, 80 + p_len);
    else
      n_pass++;
    n_checks++;
    if (sbq.size() != 0)
      $display("FAIL %s missing_vecs got %0d left want 0", tag, sbq.size());
    else
      n_pass++;
    n_checks++;
    if (err_count !== 5'(errs))
      $display("FAIL %s err_count got %0d want %0d", tag, err_count, errs);
    else
      n_pass++;
    n_checks++;
    if (err_valid !== (errs > 0))
      $display("FAIL %s err_valid got %b want %b", tag, err_valid, errs > 0);
    else
      n_pass++;
    n_checks++;
    if (first_err_idx !== 4'(first))
      $display("FAIL %s first_err got %h want %h", tag, first_err_idx, first);
    else
      n_pass++;
    n_checks++;
    if (pass !== (got_done && errs == 0))
      $display("FAIL %s pass got %b want %b", tag, pass, errs == 0);
    else
      n_pass++;
    // Results and done must hold with start low.
    tick();
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || err_count !== 5'(errs)
        || {in1, in2} !== 4'hf)
      $display("FAIL %s hold got done=%b busy=%b err=%0d vec=%h want 1 0 %0d f",
               tag, done, busy, err_count, {in1, in2}, errs);
    else
      n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    fault = 0;
    tick();
    tick();
    n_checks++;
    if ({in1, in2, busy, done, pass, err_count, err_valid, first_err_idx}
        !== '0)
      $display("FAIL reset got %h/%h b%b d%b p%b e%0d v%b f%h want all 0",
               in1, in2, busy, done, pass, err_count, err_valid,
               first_err_idx);
    else
      n_pass++;
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL idle got busy=%b done=%b want 0 0", busy, done);
    else
      n_pass++;
  endtask

  task automatic test_clean();
    run_sweep(0, 0, 0, 0, "clean");
  endtask

  task automatic test_eq_stuck();
    run_sweep(1, 0, 0, 0, "eq_stuck");
    n_checks++;
    if (err_count !== 5'd4 || first_err_idx !== 4'h0 || pass !== 1'b0)
      $display("FAIL eq_stuck_spec got %0d/%h/%b want 4/0/0",
               err_count, first_err_idx, pass);
    else
      n_pass++;
  endtask

  task automatic test_swap();
    run_sweep(2, 0, 0, 0, "swap");
    n_checks++;
    if (err_count !== 5'd12 || first_err_idx !== 4'h1 || pass !== 1'b0)
      $display("FAIL swap_spec got %0d/%h/%b want 12/1/0",
               err_count, first_err_idx, pass);
    else
      n_pass++;
  endtask

  task automatic test_zero_hot();
    run_sweep(3, 0, 0, 0, "zero_hot");
  endtask

  task automatic test_pause();
    run_sweep(0, 16, 10, 0, "pause");
  endtask

  task automatic test_hold_start();
    run_sweep(0, 0, 0, 1, "hold_start");
  endtask

  task automatic test_mid_reset();
    fault = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    n_checks++;
    if (err_count !== 5'd2)
      $display("FAIL pre_reset err got %0d want 2", err_count);
    else
      n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in1, in2, busy, done, pass, err_count, err_valid, first_err_idx}
        !== '0)
      $display("FAIL async_reset got %h/%h b%b d%b p%b e%0d v%b f%h want 0",
               in1, in2, busy, done, pass, err_count, err_valid,
               first_err_idx);
    else
      n_pass++;
    #2;
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL post_reset got busy=%b done=%b want 0 0", busy, done);
    else
      n_pass++;
    run_sweep(0, 0, 0, 0, "after_reset");
  endtask

  task automatic test_back_to_back();
    int c;
    run_sweep(1, 0, 0, 0, "b2b_first");
    fault = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0 || err_count !== 5'd0
        || err_valid !== 1'b0 || first_err_idx !== 4'h0
        || {in1, in2} !== 4'h0)
      $display("FAIL restart got b%b d%b e%0d v%b f%h vec %h want 1 0 0 0 0 0",
               busy, done, err_count, err_valid, first_err_idx, {in1, in2});
    else
      n_pass++;
    c = 0;
    while (!done && c < 200) begin
      tick();
      c++;
    end
    n_checks++;
    if (done !== 1'b1 || c != 80 || pass !== 1'b1 || err_count !== 5'd0)
      $display("FAIL restart_end got d%b cyc %0d p%b e%0d want 1 80 1 0",
               done, c, pass, err_count);
    else
      n_pass++;
  endtask

  initial begin
    test_reset();
    test_clean();
    test_eq_stuck();
    test_swap();
    test_zero_hot();
    test_pause();
    test_hold_start();
    test_mid_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
